// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl
//   Control FSM of the 1x3 router. Decodes the header address, then walks the
//   register/parity datapath through the header, payload and parity phases. It
//   stalls while the selected FIFO is full and aborts the packet on that port's
//   soft reset. Every output is registered, and each one is a decode of the state
//   the machine is entering. No input reaches an output combinationally.
//
// Ports
//   clock          rising-edge clock
//   resetn         synchronous reset, active-low
//   pkt_valid      source packet-valid
//   data_in[1:0]   header destination address (2'b11 = invalid)
//   fifo_full      full flag of the selected destination FIFO
//   fifo_empty[2:0] empty flag per destination FIFO
//   soft_reset[2:0] per-port timeout soft reset
//   parity_done    datapath has captured the parity byte
//   low_pkt_valid  pkt_valid dropped while the datapath was loading
//   write_enb_reg  FIFO write enable (LD, LAF, LP)
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                  one-hot state strobes for the datapath
//   busy           source must hold its data
//   addr_lat[1:0]  destination latched in DECODE_ADDRESS

module router_fsm_ctrl #(
  parameter int NPORT = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pkt_valid,
  input  logic [1:0]       data_in,
  input  logic             fifo_full,
  input  logic [NPORT-1:0] fifo_empty,
  input  logic [NPORT-1:0] soft_reset,
  input  logic             parity_done,
  input  logic             low_pkt_valid,
  output logic             write_enb_reg,
  output logic             detect_add,
  output logic             lfd_state,
  output logic             ld_state,
  output logic             laf_state,
  output logic             full_state,
  output logic             rst_int_reg,
  output logic             busy,
  output logic [1:0]       addr_lat
);

  typedef enum logic [2:0] {
    DA  = 3'd0,  // DECODE_ADDRESS
    LFD = 3'd1,  // LOAD_FIRST_DATA
    LD  = 3'd2,  // LOAD_DATA
    WTE = 3'd3,  // WAIT_TILL_EMPTY
    FFS = 3'd4,  // FIFO_FULL_STATE
    LAF = 3'd5,  // LOAD_AFTER_FULL
    LP  = 3'd6,  // LOAD_PARITY
    CPE = 3'd7   // CHECK_PARITY_ERROR
  } state_t;

  localparam logic [1:0] BAD_ADDR = 2'b11;

  state_t state;
  state_t state_next;

  logic addr_ok;
  logic in_empty;   // empty flag of the port named by the incoming header
  logic lat_empty;  // empty flag of the latched port
  logic lat_soft;   // soft reset of the latched port

  // Guard the variable selects so that the invalid address never indexes past the vectors.
  assign addr_ok   = (data_in != BAD_ADDR);
  assign in_empty  = addr_ok ? fifo_empty[data_in] : 1'b0;
  assign lat_empty = (addr_lat != BAD_ADDR) ? fifo_empty[addr_lat] : 1'b0;
  assign lat_soft  = (addr_lat != BAD_ADDR) ? soft_reset[addr_lat] : 1'b0;

  always_comb begin
    state_next = state;
    case (state)
      DA:  if (pkt_valid && addr_ok) state_next = in_empty ? LFD : WTE;
      LFD: state_next = LD;
      LD: begin
        if (fifo_full)       state_next = FFS;  // full wins over end-of-packet
        else if (!pkt_valid) state_next = LP;
      end
      WTE: if (lat_empty)  state_next = LFD;
      FFS: if (!fifo_full) state_next = LAF;
      LAF: begin
        if (parity_done)        state_next = DA;
        else if (low_pkt_valid) state_next = LP;
        else                    state_next = LD;
      end
      LP:  state_next = CPE;
      CPE: state_next = fifo_full ? FFS : DA;
      default: state_next = DA;
    endcase
    // A soft reset of the port in use aborts the packet from any active state.
    if (state != DA && lat_soft) state_next = DA;
  end

  // The outputs are registered from state_next. They therefore always equal a decode of state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= DA;
      addr_lat      <= 2'b00;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DA && pkt_valid && addr_ok) addr_lat <= data_in;
      detect_add    <= (state_next == DA);
      lfd_state     <= (state_next == LFD);
      ld_state      <= (state_next == LD);
      laf_state     <= (state_next == LAF);
      full_state    <= (state_next == FFS);
      rst_int_reg   <= (state_next == CPE);
      write_enb_reg <= (state_next == LD) || (state_next == LAF) || (state_next == LP);
      busy          <= !((state_next == DA) || (state_next == LD));
    end
  end

endmodule
